// File: rtl/seq_divider_if.sv
// Purpose: operand/result bundle for seq_divider (start/ready/done handshake).
// Latency: n/a (wires only).
// Backpressure: requester holds start until it sees ready; results hold until the next done.
// Signals: start, dividend[DW], divisor[VW] (requester -> divider);
//          ready, done, quotient[DW], remainder[VW], div_zero (divider -> requester);
//          check_ok only when SEQ_DIVIDER_CHECK_EN is defined.
interface seq_divider_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          ready;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;
`ifdef SEQ_DIVIDER_CHECK_EN
  logic          check_ok;
`endif

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_zero
`ifdef SEQ_DIVIDER_CHECK_EN
    , input check_ok
`endif
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_zero
`ifdef SEQ_DIVIDER_CHECK_EN
    , output check_ok
`endif
  );
endinterface

// File: rtl/seq_divider.sv
// Purpose: sequential restoring divider, DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// Latency: done visible DW+1 cycles after the start edge (1 cycle when divisor is 0).
// Backpressure: ready low while dividing; start is ignored then. Results registered and held.
// Ports: clk, rst (async, active-high); bus (seq_divider_if.slave) carries the handshake,
//        operands and results.
// Option: SEQ_DIVIDER_CHECK_EN adds bus.check_ok, a registered quotient*divisor+remainder self-check.
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [VW-1:0] r;      // partial remainder; always < divisor, so VW bits suffice between steps
  logic [DW-1:0] dq;     // dividend shifting out the top, quotient bits shifting in the bottom
  logic [VW-1:0] dvs;

  // One restoring step; the shifted remainder needs one extra bit before the subtract.
  logic [VW:0]   r_sh;
  logic [VW-1:0] r_nxt;
  logic [DW-1:0] dq_nxt;

  always_comb begin
    r_sh   = {r, dq[DW-1]};
    dq_nxt = dq << 1;
    r_nxt  = r_sh[VW-1:0];
    if (r_sh >= {1'b0, dvs}) begin
      r_nxt     = VW'(r_sh - {1'b0, dvs});
      dq_nxt[0] = 1'b1;
    end
  end

`ifdef SEQ_DIVIDER_CHECK_EN
  localparam int PW = DW + VW;
  logic [DW-1:0] dvd;
  logic          check_sum;
  always_comb begin
    check_sum = ((PW'(dq_nxt) * PW'(dvs) + PW'(r_nxt)) == PW'(dvd));
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      r             <= '0;
      dq            <= '0;
      dvs           <= '0;
      bus.ready     <= 1'b1;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
`ifdef SEQ_DIVIDER_CHECK_EN
      dvd           <= '0;
      bus.check_ok  <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        // DONE accepts a start exactly like IDLE so divisions can run back to back.
        IDLE, DONE: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
          if (bus.start) begin
            dvs   <= bus.divisor;
            dq    <= bus.dividend;
            r     <= '0;
            count <= '0;
`ifdef SEQ_DIVIDER_CHECK_EN
            dvd   <= bus.dividend;
`endif
            if (bus.divisor == '0) begin
              // No iterations: saturate the quotient and pass the low dividend bits through.
              state         <= DONE;
              bus.done      <= 1'b1;
              bus.quotient  <= '1;
              bus.remainder <= bus.dividend[VW-1:0];
              bus.div_zero  <= 1'b1;
`ifdef SEQ_DIVIDER_CHECK_EN
              bus.check_ok  <= 1'b1;
`endif
            end else begin
              state     <= RUN;
              bus.ready <= 1'b0;
            end
          end
        end
        RUN: begin
          r     <= r_nxt;
          dq    <= dq_nxt;
          count <= count + 1'b1;
          if (count == CW'(DW - 1)) begin
            state         <= DONE;
            bus.ready     <= 1'b1;
            bus.done      <= 1'b1;
            bus.quotient  <= dq_nxt;
            bus.remainder <= r_nxt;
            bus.div_zero  <= 1'b0;
`ifdef SEQ_DIVIDER_CHECK_EN
            bus.check_ok  <= check_sum;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
